// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the bit-serial subtractor: default width and FSM encoding.
package serial_subtractor_pkg;

   localparam int unsigned WIDTH_DEFAULT = 8;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: diff = a - b - bin, borrow out when a < b + bin.
module full_subtractor (
   input  logic minuend,
   input  logic subtrahend,
   input  logic borrow_in,
   output logic diff,
   output logic borrow_out
);

   assign diff       = minuend ^ subtrahend ^ borrow_in;
   assign borrow_out = (~minuend & subtrahend) | (~(minuend ^ subtrahend) & borrow_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell walks the operands LSB first,
// producing A - B - borrow_in after WIDTH shift cycles.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] minuend,
   input  logic [WIDTH-1:0] subtrahend,
   input  logic             borrow_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam int unsigned   CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             brw_q, brw_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bout_q, bout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             cell_diff;
   logic             cell_bout;

   full_subtractor u_cell (
      .minuend    (a_q[0]),
      .subtrahend (b_q[0]),
      .borrow_in  (brw_q),
      .diff       (cell_diff),
      .borrow_out (cell_bout)
   );

   // Next-state and datapath
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      brw_d   = brw_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
      busy_d  = (state_q == ST_SHIFT);
      done_d  = (state_q == ST_DONE);

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_d     = minuend;
               b_d     = subtrahend;
               brw_d   = borrow_in;
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            res_d = {cell_diff, res_q[WIDTH-1:1]};
            brw_d = cell_bout;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            // Result register is complete here; publish it alongside the done pulse
            diff_d  = res_q;
            bout_d  = brw_q;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         brw_q   <= 1'b0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         brw_q   <= brw_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign diff       = diff_q;
   assign borrow_out = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random self-checking bench for serial_subtractor at WIDTH=8.
module tb_serial_subtractor;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] minuend;
   logic [W-1:0] subtrahend;
   logic         borrow_in;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow_out;

   int n_chk  = 0;
   int n_fail = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .minuend    (minuend),
      .subtrahend (subtrahend),
      .borrow_in  (borrow_in),
      .busy       (busy),
      .done       (done),
      .diff       (diff),
      .borrow_out (borrow_out)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present operands with start for one edge, then scramble the operand pins.
   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
      start      = 1'b1;
      minuend    = a;
      subtrahend = b;
      borrow_in  = bin;
      cyc();
      start      = 1'b0;
      minuend    = W'($urandom);
      subtrahend = W'($urandom);
      borrow_in  = 1'($urandom);
   endtask

   // Wait (bounded) for done; report latency, busy cycles, busy/done overlap, early diff change.
   task automatic wait_done(output int lat, output int bcnt, output bit ovl, output bit chg);
      logic [W-1:0] prev;
      prev = diff;
      lat  = 0;
      bcnt = 0;
      ovl  = 1'b0;
      chg  = 1'b0;
      while (!done && lat < 20) begin
         cyc();
         lat++;
         if (busy) bcnt++;
         if (busy && done) ovl = 1'b1;
         if (!done && diff !== prev) chg = 1'b1;
      end
   endtask

   function automatic logic [W-1:0] exp_diff(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
      return W'((int'(a) - int'(b) - int'(bin)) & 255);
   endfunction

   function automatic logic exp_bout(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
      return (int'(a) < int'(b) + int'(bin));
   endfunction

   initial begin
      int lat, bcnt, npulse;
      bit ovl, chg;
      logic [W-1:0] ra, rb;
      logic rbin;

      rst = 1'b1; start = 1'b0; minuend = '0; subtrahend = '0; borrow_in = 1'b0;
      cyc();
      cyc();
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_diff", 32'(diff), 32'd0);
      check("reset_bout", 32'(borrow_out), 32'd0);
      rst = 1'b0;
      cyc();

      // 0x5A - 0x3C
      launch(8'h5A, 8'h3C, 1'b0);
      wait_done(lat, bcnt, ovl, chg);
      check("basic_latency", 32'(lat), 32'd9);
      check("basic_busy_cycles", 32'(bcnt), 32'd8);
      check("basic_overlap", 32'(ovl), 32'd0);
      check("basic_diff", 32'(diff), 32'h1E);
      check("basic_bout", 32'(borrow_out), 32'd0);
      cyc();
      check("done_one_cycle", 32'(done), 32'd0);

      // Wrap-around cases
      launch(8'h00, 8'h01, 1'b0);
      wait_done(lat, bcnt, ovl, chg);
      check("under1_diff", 32'(diff), 32'hFF);
      check("under1_bout", 32'(borrow_out), 32'd1);
      check("under1_hold_in_shift", 32'(chg), 32'd0);

      launch(8'h00, 8'h00, 1'b1);
      wait_done(lat, bcnt, ovl, chg);
      check("binonly_diff", 32'(diff), 32'hFF);
      check("binonly_bout", 32'(borrow_out), 32'd1);

      launch(8'hFF, 8'hFF, 1'b0);
      wait_done(lat, bcnt, ovl, chg);
      check("equal_diff", 32'(diff), 32'h00);
      check("equal_bout", 32'(borrow_out), 32'd0);
      check("equal_hold_in_shift", 32'(chg), 32'd0);
      for (int i = 0; i < 5; i++) begin
         cyc();
         check("equal_hold_diff", 32'(diff), 32'h00);
         check("equal_hold_bout", 32'(borrow_out), 32'd0);
         check("idle_busy", 32'(busy), 32'd0);
      end

      // Start and operand changes during SHIFT are ignored
      launch(8'h5A, 8'h3C, 1'b0);
      cyc();
      start = 1'b1; minuend = 8'hFF; subtrahend = 8'h01; borrow_in = 1'b1;
      cyc();
      start = 1'b0;
      wait_done(lat, bcnt, ovl, chg);
      check("ignore_latency", 32'(lat), 32'd7);
      check("ignore_diff", 32'(diff), 32'h1E);
      check("ignore_bout", 32'(borrow_out), 32'd0);
      npulse = 0;
      for (int i = 0; i < 12; i++) begin
         cyc();
         if (done) npulse++;
      end
      check("ignore_extra_done", 32'(npulse), 32'd0);

      // Reset in the 4th SHIFT cycle aborts the operation
      launch(8'h5A, 8'h3C, 1'b0);
      cyc();
      cyc();
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_diff", 32'(diff), 32'd0);
      check("abort_bout", 32'(borrow_out), 32'd0);
      npulse = 0;
      for (int i = 0; i < 12; i++) begin
         cyc();
         if (done) npulse++;
         if (busy) npulse++;
      end
      check("abort_no_activity", 32'(npulse), 32'd0);

      launch(8'h10, 8'h01, 1'b0);
      wait_done(lat, bcnt, ovl, chg);
      check("after_abort_latency", 32'(lat), 32'd9);
      check("after_abort_diff", 32'(diff), 32'h0F);
      check("after_abort_bout", 32'(borrow_out), 32'd0);

      // Back-to-back random operations
      for (int i = 0; i < 1000; i++) begin
         ra   = W'($urandom);
         rb   = W'($urandom);
         rbin = 1'($urandom);
         launch(ra, rb, rbin);
         wait_done(lat, bcnt, ovl, chg);
         check("rand_latency", 32'(lat), 32'd9);
         check("rand_diff", 32'(diff), 32'(exp_diff(ra, rb, rbin)));
         check("rand_bout", 32'(borrow_out), 32'(exp_bout(ra, rb, rbin)));
         check("rand_overlap", 32'(ovl), 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
